// File: rtl/ex_div_seq.sv
// ex_div_seq -- multi-cycle DIV/DIVU/REM/REMU sequencer for the EX stage.
//
// Sits beside the single-cycle ALU. A divide-class op is captured from the EX
// bundle, then an iterative restoring divider resolves UNROLL quotient bits
// per cycle. The pipeline is held through stall_o until the EX/MEM register
// takes the result. Divide-by-zero and signed overflow take a 1-cycle path.
//
// Handshake: res_valid_o is high for every cycle the FSM sits in DONE. The
// result is consumed on the rising edge where res_valid_o & ready_i are both
// high; res_o/res_rd_o stay constant until then. flush_i wins over start_i
// and ready_i in the same cycle and returns the FSM to IDLE.
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   start_i       divide-class op present in EX (looked at only in IDLE)
//   op_i          00 DIV, 01 DIVU, 10 REM, 11 REMU
//   opr_a_i       dividend
//   opr_b_i       divisor
//   rd_i          destination register
//   flush_i       kill any in-flight op
//   ready_i       EX/MEM accepts the result this cycle
//   stall_o       freeze IF/ID/EX (combinational)
//   res_valid_o   result and rd valid
//   res_o         quotient or remainder
//   res_rd_o      rd of the result
//
// UNROLL must be 1, 2 or 4 and must divide XLEN.

module ex_div_seq #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] opr_a_i,
  input  logic [XLEN-1:0] opr_b_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  input  logic            ready_i,
  output logic            stall_o,
  output logic            res_valid_o,
  output logic [XLEN-1:0] res_o,
  output logic [4:0]      res_rd_o
);

  localparam int STEPS = XLEN / UNROLL;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STEPS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // State
  logic [1:0]      state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [XLEN-1:0] rem_q,      rem_d;
  logic [XLEN-1:0] quot_q,     quot_d;
  logic [XLEN-1:0] divisor_q,  divisor_d;
  logic            is_rem_q,   is_rem_d;
  logic            neg_quot_q, neg_quot_d;
  logic            neg_rem_q,  neg_rem_d;
  logic [4:0]      rd_q,       rd_d;
  logic [XLEN-1:0] res_q,      res_d;
  logic [4:0]      res_rd_q,   res_rd_d;

  // Operand decode in IDLE
  logic            in_signed;
  logic            in_is_rem;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            b_zero;
  logic            sgn_ovf;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    in_signed = ~op_i[0];
    in_is_rem = op_i[1];
    a_neg     = in_signed & opr_a_i[XLEN-1];
    b_neg     = in_signed & opr_b_i[XLEN-1];
    // |INT_MIN| wraps to INT_MIN, which is still the right unsigned magnitude.
    a_mag     = a_neg ? (-opr_a_i) : opr_a_i;
    b_mag     = b_neg ? (-opr_b_i) : opr_b_i;
    b_zero    = (opr_b_i == '0);
    sgn_ovf   = in_signed & (opr_a_i == INT_MIN) & (opr_b_i == '1);
    // Fast-path results bypass sign fix-up entirely.
    if (b_zero) begin
      fast_res = in_is_rem ? opr_a_i : '1;
    end else begin
      fast_res = in_is_rem ? '0 : INT_MIN;
    end
  end

  // UNROLL restoring steps on the current partial remainder/quotient.
  // The trial subtraction is XLEN+1 bits wide: the shifted remainder can
  // reach 2*|b|-1, which overflows XLEN bits for large unsigned divisors.
  logic [XLEN-1:0] rem_v;
  logic [XLEN-1:0] quot_v;
  logic [XLEN:0]   shifted_v;
  logic [XLEN:0]   trial_v;

  always_comb begin
    rem_v     = rem_q;
    quot_v    = quot_q;
    shifted_v = '0;
    trial_v   = '0;
    for (int s = 0; s < UNROLL; s++) begin
      shifted_v = {rem_v, quot_v[XLEN-1]};
      trial_v   = shifted_v - {1'b0, divisor_q};
      if (!trial_v[XLEN]) begin
        rem_v = trial_v[XLEN-1:0];
      end else begin
        rem_v = shifted_v[XLEN-1:0];
      end
      quot_v = {quot_v[XLEN-2:0], ~trial_v[XLEN]};
    end
  end

  // Sign fix-up on the final step's output, selected by op.
  logic [XLEN-1:0] quot_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] calc_res;

  always_comb begin
    quot_fix = neg_quot_q ? (-quot_v) : quot_v;
    rem_fix  = neg_rem_q  ? (-rem_v)  : rem_v;
    calc_res = is_rem_q ? rem_fix : quot_fix;
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    divisor_d  = divisor_q;
    is_rem_d   = is_rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    rd_d       = rd_q;
    res_d      = res_q;
    res_rd_d   = res_rd_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i && !flush_i) begin
          is_rem_d   = in_is_rem;
          rd_d       = rd_i;
          neg_quot_d = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          if (b_zero || sgn_ovf) begin
            state_d  = ST_DONE;
            res_d    = fast_res;
            res_rd_d = rd_i;
          end else begin
            state_d   = ST_CALC;
            cnt_d     = CNT_INIT;
            rem_d     = '0;
            quot_d    = a_mag;
            divisor_d = b_mag;
          end
        end
      end

      ST_CALC: begin
        rem_d  = rem_v;
        quot_d = quot_v;
        if (cnt_q == '0) begin
          state_d  = ST_DONE;
          res_d    = calc_res;
          res_rd_d = rd_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_DONE: begin
        // start_i is deliberately ignored here so the op that is still
        // sitting in EX cannot launch a second divide.
        if (ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (flush_i) begin
      state_d = ST_IDLE;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      divisor_q  <= '0;
      is_rem_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      rd_q       <= '0;
      res_q      <= '0;
      res_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      divisor_q  <= divisor_d;
      is_rem_q   <= is_rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      rd_q       <= rd_d;
      res_q      <= res_d;
      res_rd_q   <= res_rd_d;
    end
  end

  // Outputs. stall_o drops in the DONE&ready_i cycle so the EX instruction
  // advances on the same edge the result is taken.
  assign stall_o     = !flush_i & (((state_q == ST_IDLE) & start_i) |
                                   (state_q == ST_CALC) |
                                   ((state_q == ST_DONE) & !ready_i));
  assign res_valid_o = (state_q == ST_DONE);
  assign res_o       = res_q;
  assign res_rd_o    = res_rd_q;

endmodule

// File: tb/tb_ex_div_seq.sv
// tb_ex_div_seq -- self-checking bench for ex_div_seq.
// Two instances (UNROLL=1 and UNROLL=4) share the stimulus; tb_sel picks
// which one receives start_i and which one's outputs are observed.

module tb_ex_div_seq;

  localparam int XLEN  = 32;
  localparam int BOUND = 100;

  // Clock / reset
  logic clk = 1'b0;
  logic tb_rst_n = 1'b0;
  always #5 clk = ~clk;

  // Stimulus
  logic        tb_sel   = 1'b0;
  logic        tb_start = 1'b0;
  logic [1:0]  tb_op    = 2'b00;
  logic [31:0] tb_a     = '0;
  logic [31:0] tb_b     = '0;
  logic [4:0]  tb_rd    = '0;
  logic        tb_flush = 1'b0;
  logic        tb_ready = 1'b0;

  // DUT outputs
  logic        stall1, valid1, stall4, valid4;
  logic [31:0] res1, res4;
  logic [4:0]  rdo1, rdo4;

  logic        stall, valid;
  logic [31:0] res;
  logic [4:0]  res_rd;

  assign stall  = tb_sel ? stall4 : stall1;
  assign valid  = tb_sel ? valid4 : valid1;
  assign res    = tb_sel ? res4   : res1;
  assign res_rd = tb_sel ? rdo4   : rdo1;

  ex_div_seq #(.XLEN(XLEN), .UNROLL(1)) dut1 (
    .clk         (clk),
    .rst_n       (tb_rst_n),
    .start_i     (tb_start & !tb_sel),
    .op_i        (tb_op),
    .opr_a_i     (tb_a),
    .opr_b_i     (tb_b),
    .rd_i        (tb_rd),
    .flush_i     (tb_flush),
    .ready_i     (tb_ready),
    .stall_o     (stall1),
    .res_valid_o (valid1),
    .res_o       (res1),
    .res_rd_o    (rdo1)
  );

  ex_div_seq #(.XLEN(XLEN), .UNROLL(4)) dut4 (
    .clk         (clk),
    .rst_n       (tb_rst_n),
    .start_i     (tb_start & tb_sel),
    .op_i        (tb_op),
    .opr_a_i     (tb_a),
    .opr_b_i     (tb_b),
    .rd_i        (tb_rd),
    .flush_i     (tb_flush),
    .ready_i     (tb_ready),
    .stall_o     (stall4),
    .res_valid_o (valid4),
    .res_o       (res4),
    .res_rd_o    (rdo4)
  );

  int errors   = 0;
  int n_checks = 0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  // Reference model: plain arithmetic with the RISC-V special cases.
  function automatic logic [31:0] model_res(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (!o[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return o[1] ? r : q;
  endfunction

  function automatic bit model_fast(input logic [1:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Driver: issue one op, hold ready_i low for 'hold' DONE cycles, then
  // consume. Reports latency (cycles after the start edge), first result,
  // stall cycles, valid cycles, result stability and stray valids afterwards.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input int hold, input bit keep_start,
                        output int lat, output logic [31:0] res_seen,
                        output logic [4:0] rd_seen, output int stall_cnt,
                        output int valid_cnt, output bit stable, output int extra);
    int  done_cyc;
    bit  finished;
    lat = -1; res_seen = '0; rd_seen = '0; stall_cnt = 0; valid_cnt = 0;
    stable = 1'b1; extra = 0; done_cyc = 0; finished = 1'b0;
    @(negedge clk);
    tb_start = 1'b1; tb_op = o; tb_a = a; tb_b = b; tb_rd = r; tb_ready = 1'b0;
    #1;
    if (stall) stall_cnt++;
    @(posedge clk);
    #1;
    if (!keep_start) tb_start = 1'b0;
    tb_a = $urandom; tb_b = $urandom; tb_rd = 5'($urandom);
    for (int c = 1; c <= BOUND && !finished; c++) begin
      @(negedge clk);
      if (valid) begin
        done_cyc++;
        tb_ready = (done_cyc > hold);
      end else begin
        tb_ready = 1'b0;
      end
      #1;
      if (stall) stall_cnt++;
      if (valid) begin
        valid_cnt++;
        if (lat < 0) begin
          lat = c; res_seen = res; rd_seen = res_rd;
        end else if (res !== res_seen || res_rd !== rd_seen) begin
          stable = 1'b0;
        end
        if (tb_ready) finished = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    tb_start = 1'b0; tb_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (valid) extra++;
    end
  endtask

  task automatic test_reset;
    tb_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    for (int s = 0; s < 2; s++) begin
      tb_sel = s[0];
      @(negedge clk);
      #1;
      n_checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall sel=%0d got=%b exp=0", s, stall); end
      n_checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid sel=%0d got=%b exp=0", s, valid); end
      n_checks++; if (res !== 32'd0) begin errors++; $display("FAIL reset_res sel=%0d got=%h exp=0", s, res); end
      n_checks++; if (res_rd !== 5'd0) begin errors++; $display("FAIL reset_rd sel=%0d got=%0d exp=0", s, res_rd); end
    end
    tb_rst_n = 1'b1;
    tb_sel = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (valid !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL post_reset_idle got valid=%b stall=%b exp 0/0", valid, stall); end
  endtask

  task automatic test_unsigned_basic;
    int lat, sc, vc, ex; logic [31:0] r; logic [4:0] d; bit st;
    tb_sel = 1'b0;
    run_op(OP_DIVU, 32'd100, 32'd7, 5'd9, 0, 1'b0, lat, r, d, sc, vc, st, ex);
    n_checks++; if (r !== 32'd14) begin errors++; $display("FAIL divu_100_7 got=%h exp=%h", r, 32'd14); end
    n_checks++; if (lat !== 33) begin errors++; $display("FAIL divu_latency got=%0d exp=33", lat); end
    n_checks++; if (sc !== 33) begin errors++; $display("FAIL divu_stall_cycles got=%0d exp=33", sc); end
    n_checks++; if (vc !== 1) begin errors++; $display("FAIL divu_valid_cycles got=%0d exp=1", vc); end
    n_checks++; if (d !== 5'd9) begin errors++; $display("FAIL divu_rd got=%0d exp=9", d); end
    run_op(OP_REMU, 32'd100, 32'd7, 5'd17, 0, 1'b0, lat, r, d, sc, vc, st, ex);
    n_checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu_100_7 got=%h exp=%h", r, 32'd2); end
    n_checks++; if (d !== 5'd17) begin errors++; $display("FAIL remu_rd got=%0d exp=17", d); end
  endtask

  task automatic test_signed;
    int lat, sc, vc, ex; logic [31:0] r; logic [4:0] d; bit st;
    tb_sel = 1'b0;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3, 0, 1'b0, lat, r, d, sc, vc, st, ex);
    n_checks++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2 got=%h exp=fffffffd", r); end
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd4, 0, 1'b0, lat, r, d, sc, vc, st, ex);
    n_checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_m7_2 got=%h exp=ffffffff", r); end
    run_op(OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd5, 0, 1'b0, lat, r, d, sc, vc, st, ex);
    n_checks++; if (r !== 32'd1) begin errors++; $display("FAIL rem_7_m2 got=%h exp=1", r); end
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd6, 0, 1'b0, lat, r, d, sc, vc, st, ex);
    n_checks++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_7_m2 got=%h exp=fffffffd", r); end
  endtask

  task automatic test_fast_path;
    int lat, sc, vc, ex; logic [31:0] r; logic [4:0] d; bit st;
    tb_sel = 1'b0;
    run_op(OP_DIVU, 32'd5, 32'd0, 5'd1, 0, 1'b0, lat, r, d, sc, vc, st, ex);
    n_checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_by0 got=%h exp=ffffffff", r); end
    n_checks++; if (lat !== 1) begin errors++; $display("FAIL divu_by0_latency got=%0d exp=1", lat); end
    n_checks++; if (sc !== 1) begin errors++; $display("FAIL divu_by0_stall got=%0d exp=1", sc); end
    n_checks++; if (d !== 5'd1) begin errors++; $display("FAIL divu_by0_rd got=%0d exp=1", d); end
    run_op(OP_REMU, 32'd5, 32'd0, 5'd2, 0, 1'b0, lat, r, d, sc, vc, st, ex);
    n_checks++; if (r !== 32'd5) begin errors++; $display("FAIL remu_by0 got=%h exp=5", r); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 0, 1'b0, lat, r, d, sc, vc, st, ex);
    n_checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf got=%h exp=80000000", r); end
    n_checks++; if (lat !== 1) begin errors++; $display("FAIL div_ovf_latency got=%0d exp=1", lat); end
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 0, 1'b0, lat, r, d, sc, vc, st, ex);
    n_checks++; if (r !== 32'd0) begin errors++; $display("FAIL rem_ovf got=%h exp=0", r); end
    run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 0, 1'b0, lat, r, d, sc, vc, st, ex);
    n_checks++; if (r !== 32'd0 || lat !== 33) begin errors++; $display("FAIL divu_no_ovf got=%h lat=%0d exp=0 lat=33", r, lat); end
  endtask

  task automatic test_ready_hold;
    int lat, sc, vc, ex; logic [31:0] r; logic [4:0] d; bit st;
    tb_sel = 1'b0;
    // start_i kept high through DONE: it must not relaunch the op.
    run_op(OP_DIVU, 32'd1000, 32'd9, 5'd21, 3, 1'b1, lat, r, d, sc, vc, st, ex);
    n_checks++; if (r !== 32'd111) begin errors++; $display("FAIL hold_res got=%h exp=%h", r, 32'd111); end
    n_checks++; if (vc !== 4) begin errors++; $display("FAIL hold_valid_cycles got=%0d exp=4", vc); end
    n_checks++; if (st !== 1'b1) begin errors++; $display("FAIL hold_stable got=%b exp=1", st); end
    n_checks++; if (sc !== 36) begin errors++; $display("FAIL hold_stall_cycles got=%0d exp=36", sc); end
    n_checks++; if (ex !== 0) begin errors++; $display("FAIL hold_second_result got=%0d exp=0", ex); end
  endtask

  // Kill in the 10th CALC cycle by flush (use_rst=0) or by reset (use_rst=1).
  task automatic test_kill(input bit use_rst);
    int lat, sc, vc, ex, seen; logic [31:0] r; logic [4:0] d; bit st;
    tb_sel = 1'b0;
    @(negedge clk);
    tb_start = 1'b1; tb_op = OP_DIVU; tb_a = 32'd1000; tb_b = 32'd3; tb_rd = 5'd7;
    @(posedge clk);
    #1;
    tb_start = 1'b0;
    repeat (9) @(negedge clk);
    @(negedge clk);
    if (use_rst) tb_rst_n = 1'b0; else tb_flush = 1'b1;
    #1;
    if (!use_rst) begin
      n_checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_cycle_stall got=%b exp=0", stall); end
    end
    @(posedge clk);
    #1;
    tb_flush = 1'b0; tb_rst_n = 1'b1;
    @(negedge clk);
    #1;
    seen = 0;
    if (valid) seen++;
    n_checks++; if (stall !== 1'b0) begin errors++; $display("FAIL kill_idle_stall rst=%0d got=%b exp=0", use_rst, stall); end
    if (use_rst) begin
      n_checks++; if (res !== 32'd0) begin errors++; $display("FAIL kill_rst_res got=%h exp=0", res); end
    end
    // New op launched two cycles after the kill; the killed op must never surface.
    run_op(OP_DIVU, 32'd500, 32'd6, 5'd12, 0, 1'b0, lat, r, d, sc, vc, st, ex);
    n_checks++; if (seen !== 0) begin errors++; $display("FAIL kill_valid rst=%0d got=%0d exp=0", use_rst, seen); end
    n_checks++; if (r !== 32'd83 || lat !== 33) begin errors++; $display("FAIL kill_restart rst=%0d got=%h lat=%0d exp=53 lat=33", use_rst, r, lat); end
    n_checks++; if (d !== 5'd12 || vc !== 1) begin errors++; $display("FAIL kill_restart_rd rst=%0d got=%0d vc=%0d exp=12 vc=1", use_rst, d, vc); end
  endtask

  task automatic test_unroll4;
    int lat, sc, vc, ex; logic [31:0] r; logic [4:0] d; bit st;
    tb_sel = 1'b1;
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd3, 5'd30, 0, 1'b0, lat, r, d, sc, vc, st, ex);
    n_checks++; if (r !== 32'h5555_5555) begin errors++; $display("FAIL u4_divu got=%h exp=55555555", r); end
    n_checks++; if (lat !== 9) begin errors++; $display("FAIL u4_latency got=%0d exp=9", lat); end
    n_checks++; if (sc !== 9) begin errors++; $display("FAIL u4_stall got=%0d exp=9", sc); end
    tb_sel = 1'b0;
  endtask

  task automatic test_random(input bit s, input int n);
    int lat, sc, vc, ex, hold, steps, exp_lat; logic [31:0] r, a, b, exp_r; logic [4:0] d, rd;
    logic [1:0] o; bit st;
    tb_sel = s;
    steps = s ? 8 : 32;
    for (int i = 0; i < n; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 200); b = $urandom_range(1, 12);
                 if ($urandom_range(0, 1) == 1) a = -a;
                 if ($urandom_range(0, 1) == 1) b = -b; end
        3: b = $urandom >> $urandom_range(0, 31);
        default: ;
      endcase
      rd = 5'($urandom);
      hold = $urandom_range(0, 2);
      exp_r = model_res(o, a, b);
      exp_lat = model_fast(o, a, b) ? 1 : steps + 1;
      run_op(o, a, b, rd, hold, 1'b0, lat, r, d, sc, vc, st, ex);
      n_checks++; if (r !== exp_r) begin errors++; $display("FAIL rand_res u=%0d op=%0d a=%h b=%h got=%h exp=%h", steps, o, a, b, r, exp_r); end
      n_checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rand_lat u=%0d op=%0d got=%0d exp=%0d", steps, o, lat, exp_lat); end
      n_checks++; if (d !== rd) begin errors++; $display("FAIL rand_rd got=%0d exp=%0d", d, rd); end
      n_checks++; if (vc !== hold + 1 || sc !== exp_lat + hold) begin errors++; $display("FAIL rand_hs vc=%0d sc=%0d exp vc=%0d sc=%0d", vc, sc, hold + 1, exp_lat + hold); end
      n_checks++; if (ex !== 0 || st !== 1'b1) begin errors++; $display("FAIL rand_after extra=%0d stable=%b exp 0/1", ex, st); end
    end
    tb_sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_fast_path();
    test_ready_hold();
    test_kill(1'b0);
    test_kill(1'b1);
    test_unroll4();
    test_random(1'b0, 30);
    test_random(1'b1, 30);
    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout reached without finishing");
    $fatal(1, "timeout");
  end

endmodule
